// File: rtl/updown_counter_guard_pkg.sv
// Shared types and arithmetic for the lives/score counters.
package updown_counter_guard_pkg;

  typedef enum logic {
    SAT  = 1'b0,
    WRAP = 1'b1
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Bounded add/sub over the range 0..max. Returns {clip, result}.
  // Operands are carried at 32 bits so every caller width fits without overflow.
  function automatic logic [32:0] bounded_step(
    input logic [31:0] q,
    input logic [31:0] s,
    input logic [31:0] max,
    input logic        dir,
    input mode_e       mode
  );
    logic [31:0] m;
    logic [31:0] sum;
    logic [31:0] r;
    logic        c;
    m   = max + 32'd1;
    sum = q + s;
    if (dir == DIR_UP) begin
      c = (sum > max);
      if (!c)               r = sum;
      else if (mode == WRAP) r = sum % m;
      else                  r = max;
    end else begin
      c = (s > q);
      if (!c)               r = q - s;
      else if (mode == WRAP) r = (q + m - (s % m)) % m;
      else                  r = '0;
    end
    return {c, r};
  endfunction

endpackage

// File: rtl/updown_counter_guard_if.sv
// Control/status bundle between the game FSM and the lives/score counter.
interface updown_counter_guard_if #(
  parameter int N      = 4,
  parameter int STEP_W = 2
);
  logic              clr;
  logic              ld;
  logic [N-1:0]      D;
  logic              ent;
  logic              enp;
  logic              up;
  logic [STEP_W-1:0] step;
  logic              wrap;
  logic [N-1:0]      Q;
  logic              rco;
  logic              zero;
  logic              full;
  logic              guard_active;
  logic              dec_pulse;
  logic              clip;

  modport master (
    output clr, ld, D, ent, enp, up, step, wrap,
    input  Q, rco, zero, full, guard_active, dec_pulse, clip
  );

  modport slave (
    input  clr, ld, D, ent, enp, up, step, wrap,
    output Q, rco, zero, full, guard_active, dec_pulse, clip
  );
endinterface

// File: rtl/updown_counter_guard_guard_timer.sv
// Decrement lock-out timer: loads GUARD, counts down to zero.
module updown_counter_guard_guard_timer #(
  parameter int GUARD   = 8,
  parameter int GUARD_W = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic clear_i,
  output logic active_o,
  output logic hold_o
);

  logic [GUARD_W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load, otherwise free-running decrement to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)            cnt_d = '0;
    else if (load_i)        cnt_d = GUARD_W'(GUARD);
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  // Timer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign active_o = (cnt_q != '0);
  // On the last active cycle (count 1) the lock-out releases at the coming
  // edge, so a decrement presented then is taken; only counts above 1 block.
  // This makes the next accepted decrement land exactly GUARD cycles later.
  assign hold_o   = (cnt_q > GUARD_W'(1));

endmodule

// File: rtl/updown_counter_guard.sv
// Up/down counter with variable step, saturate/wrap mode, bounds and a
// post-decrement guard window (lives counter invulnerability).
module updown_counter_guard
  import updown_counter_guard_pkg::*;
#(
  parameter int N       = 4,
  parameter int INIT    = 3,
  parameter int MAX     = 2**N - 1,
  parameter int STEP_W  = 2,
  parameter int GUARD   = 8,
  parameter int GUARD_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  updown_counter_guard_if.slave  bus
);

  localparam logic [N-1:0] MAX_Q  = N'(MAX);
  localparam logic [N-1:0] INIT_Q = N'(INIT);

  logic [N-1:0] q_q, q_d;
  logic         dec_pulse_q, dec_pulse_d;
  logic         clip_q, clip_d;
  logic         count_ev;
  logic         guard_hold;
  logic         guard_active;
  logic         guard_load;
  logic         guard_clear;
  logic         step_clip;
  logic [31:0]  step_val;

  updown_counter_guard_guard_timer #(
    .GUARD   (GUARD),
    .GUARD_W (GUARD_W)
  ) u_guard (
    .clock    (clock),
    .reset    (reset),
    .load_i   (guard_load),
    .clear_i  (guard_clear),
    .active_o (guard_active),
    .hold_o   (guard_hold)
  );

  // Candidate count result for the current Q, step, direction and mode.
  always_comb begin
    {step_clip, step_val} = bounded_step(32'(q_q), 32'(bus.step), 32'(MAX),
                                         bus.up, mode_e'(bus.wrap));
  end

  // A zero step is not an event at all: no pulses, no guard reload.
  assign count_ev = bus.ent && bus.enp && (bus.step != '0);

  // Next-state: clr > ld > count; blocked decrements leave everything alone.
  always_comb begin
    q_d         = q_q;
    dec_pulse_d = 1'b0;
    clip_d      = 1'b0;
    guard_load  = 1'b0;
    guard_clear = 1'b0;
    if (bus.clr) begin
      q_d         = INIT_Q;
      guard_clear = 1'b1;
    end else if (bus.ld) begin
      q_d         = (bus.D > MAX_Q) ? MAX_Q : bus.D;
      guard_clear = 1'b1;
    end else if (count_ev && !(bus.up == DIR_DOWN && guard_hold)) begin
      q_d    = N'(step_val);
      clip_d = step_clip;
      if (bus.up == DIR_DOWN) begin
        guard_load  = 1'b1;
        dec_pulse_d = (q_d != q_q);
      end
    end
  end

  // Counter value and one-cycle event pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q         <= INIT_Q;
      dec_pulse_q <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      q_q         <= q_d;
      dec_pulse_q <= dec_pulse_d;
      clip_q      <= clip_d;
    end
  end

  assign bus.Q            = q_q;
  assign bus.zero         = (q_q == '0);
  assign bus.full         = (q_q == MAX_Q);
  assign bus.rco          = bus.ent && ((bus.up == DIR_DOWN && q_q == '0) ||
                                        (bus.up == DIR_UP   && q_q == MAX_Q));
  assign bus.guard_active = guard_active;
  assign bus.dec_pulse    = dec_pulse_q;
  assign bus.clip         = clip_q;

endmodule
